// File: rtl/mac_neuron.sv
// Multiply-accumulate neuron: bias plus an N-element dot product of Q1.6.1 operands,
// rescaled back to Q1.6.1 with saturation and handed downstream over a valid/ready pair.
module mac_neuron #(
  parameter int N = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] x_in,
  input  logic [7:0] w_in,
  input  logic [7:0] bias_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_sat
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [0:0] ST_ACC = 1'b0;
  localparam logic [0:0] ST_OUT = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic signed [23:0] acc_q, acc_d;
  logic [7:0]         data_q, data_d;
  logic               sat_q, sat_d;

  logic               beat;
  logic               firstBeat;
  logic               lastBeat;
  logic signed [15:0] product;
  logic signed [23:0] accBase;
  logic signed [23:0] accSum;
  logic signed [23:0] scaled;

  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_OUT);
  assign out_data  = data_q;
  assign out_sat   = sat_q;

  assign beat      = in_valid && in_ready;
  assign firstBeat = (cnt_q == '0);
  assign lastBeat  = (cnt_q == CW'(N - 1));

  // The first beat of a vector seeds the accumulator with the bias, aligned to product scale.
  always_comb begin
    product = $signed(x_in) * $signed(w_in);
    accBase = firstBeat ? {{10{bias_in[7]}}, bias_in, 6'b0} : acc_q;
    accSum  = accBase + {{8{product[15]}}, product};
    scaled  = accSum >>> 6;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    data_d  = data_q;
    sat_d   = sat_q;
    case (state_q)
      ST_ACC: begin
        if (beat) begin
          acc_d = accSum;
          if (lastBeat) begin
            cnt_d   = '0;
            state_d = ST_OUT;
            // Result is captured once here so it stays frozen while downstream stalls.
            if (scaled > 24'sd127) begin
              data_d = 8'h7F;
              sat_d  = 1'b1;
            end else if (scaled < -24'sd128) begin
              data_d = 8'h80;
              sat_d  = 1'b1;
            end else begin
              data_d = scaled[7:0];
              sat_d  = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        if (out_ready) begin
          state_d = ST_ACC;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACC;
      cnt_q   <= '0;
      acc_q   <= '0;
      data_q  <= 8'h00;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      sat_q   <= sat_d;
    end
  end

endmodule

// File: tb/tb_mac_neuron.sv
// Self-checking bench for mac_neuron: directed corner vectors plus randomized vectors
// compared against an integer-arithmetic reference of the neuron equation.
module tb_mac_neuron;

  localparam int N = 4;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] x_in;
  logic [7:0] w_in;
  logic [7:0] bias_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_sat;

  int checks = 0;
  int errors = 0;

  int vecX [N];
  int vecW [N];
  int vecBias;

  mac_neuron #(.N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x_in     (x_in),
    .w_in     (w_in),
    .bias_in  (bias_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sat  (out_sat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Every comparison in the bench funnels through here.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference: bias*64 + sum(x*w), divided by 64 rounding toward minus infinity, clamped to int8.
  task automatic modelResult(output logic [7:0] expData, output logic expSat);
    int acc;
    int q;
    acc = vecBias * 64;
    for (int i = 0; i < N; i++) acc += vecX[i] * vecW[i];
    q = acc / 64;
    if ((acc % 64 != 0) && (acc < 0)) q = q - 1;
    expSat = 1'b0;
    if (q > 127) begin
      q = 127;
      expSat = 1'b1;
    end else if (q < -128) begin
      q = -128;
      expSat = 1'b1;
    end
    expData = 8'(q);
  endtask

  task automatic setUniform(input int x, input int w, input int b);
    for (int i = 0; i < N; i++) begin
      vecX[i] = x;
      vecW[i] = w;
    end
    vecBias = b;
  endtask

  task automatic setRandom();
    for (int i = 0; i < N; i++) begin
      vecX[i] = int'($urandom_range(0, 255)) - 128;
      vecW[i] = int'($urandom_range(0, 255)) - 128;
    end
    vecBias = int'($urandom_range(0, 255)) - 128;
  endtask

  // Presents the first 'beats' elements of the current vector, with random idle gaps
  // carrying junk data; bias is only meaningful on the first beat, so later beats get junk.
  task automatic applyStimulus(input string tag, input int beats, input int maxGap);
    int gaps;
    for (int i = 0; i < beats; i++) begin
      gaps = int'($urandom_range(0, maxGap));
      repeat (gaps) begin
        in_valid = 1'b0;
        x_in     = 8'($urandom);
        w_in     = 8'($urandom);
        bias_in  = 8'($urandom);
        @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      x_in     = 8'(vecX[i]);
      w_in     = 8'(vecW[i]);
      bias_in  = (i == 0) ? 8'(vecBias) : 8'($urandom);
      if (i == N - 1) checkOutput({tag, "/early_valid"}, 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  // Checks the result one cycle after the last beat, stalls 'hold' cycles, then consumes it.
  task automatic checkResult(input string tag, input int hold);
    logic [7:0] expData;
    logic       expSat;
    modelResult(expData, expSat);
    checkOutput({tag, "/out_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "/in_ready_low"}, 32'(in_ready), 32'd0);
    checkOutput({tag, "/out_data"}, 32'(out_data), 32'(expData));
    checkOutput({tag, "/out_sat"}, 32'(out_sat), 32'(expSat));
    repeat (hold) begin
      in_valid = 1'b1;
      x_in     = 8'($urandom);
      w_in     = 8'($urandom);
      bias_in  = 8'($urandom);
      @(posedge clk);
      #1;
      checkOutput({tag, "/stall_ready"}, 32'(in_ready), 32'd0);
      checkOutput({tag, "/stall_data"}, 32'(out_data), 32'(expData));
      checkOutput({tag, "/stall_sat"}, 32'(out_sat), 32'(expSat));
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checkOutput({tag, "/release_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "/release_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x_in      = 8'h00;
    w_in      = 8'h00;
    bias_in   = 8'h00;
    #12;
    checkOutput("reset/out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset/out_data", 32'(out_data), 32'h00);
    checkOutput("reset/out_sat", 32'(out_sat), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset/in_ready", 32'(in_ready), 32'd1);

    setUniform(16, 64, -16);
    applyStimulus("basic", N, 0);
    checkResult("basic", 0);
    checkOutput("basic/value", 32'(out_data), 32'(out_data));

    setUniform(64, 64, 0);
    applyStimulus("sat_pos", N, 0);
    checkResult("sat_pos", 0);

    setUniform(-64, 64, 0);
    applyStimulus("sat_neg", N, 0);
    checkResult("sat_neg", 0);

    setUniform(-1, 1, 0);
    applyStimulus("floor_neg", N, 0);
    checkResult("floor_neg", 0);

    setUniform(1, 1, 0);
    applyStimulus("floor_pos", N, 0);
    checkResult("floor_pos", 0);

    setUniform(16, 64, -16);
    applyStimulus("stall", N, 0);
    checkResult("stall", 5);
    setUniform(16, 64, 32);
    applyStimulus("after_stall", N, 0);
    checkResult("after_stall", 0);

    setRandom();
    applyStimulus("gap_free", N, 0);
    checkResult("gap_free", 0);
    applyStimulus("gapped", N, 4);
    checkResult("gapped", 0);

    setUniform(100, 100, 50);
    applyStimulus("abort", 2, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort/out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort/out_data", 32'(out_data), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      checkOutput("abort/no_stale", 32'(out_valid), 32'd0);
    end
    setRandom();
    applyStimulus("post_abort", N, 2);
    checkResult("post_abort", 0);

    for (int v = 0; v < 40; v++) begin
      setRandom();
      applyStimulus("random", N, 3);
      checkResult("random", int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete, got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
